// File: rtl/OpCodes.sv
// Shared op-code package: issue width, payload width and the queued memory-op record.
package OpCodes;

   localparam int REGLD_PER_CLK = 2;
   localparam int NSIG          = 7;

   typedef struct packed {
      logic            is_store;
      logic [NSIG:0]   data;
   } ldst_op_t;

endpackage

// File: rtl/ldst_op_fifo.sv
// In-order op queue: one push per clk, pop of 0..LANES entries per clk,
// with the LANES oldest entries always visible on the peek outputs.
module ldst_op_fifo
   import OpCodes::*;
#(
   parameter  int DEPTH = 8,
   parameter  int LANES = REGLD_PER_CLK,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            push,
   input  ldst_op_t        push_op,
   input  logic [CW-1:0]   pop_n,
   output ldst_op_t        peek [LANES],
   output logic [CW-1:0]   count
);

   ldst_op_t        mem [DEPTH];
   logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]   count_reg, count_next;

   // Pointer and occupancy update; DEPTH is a power of two so pointers wrap by truncation.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
         end
         rd_ptr_next = rd_ptr_reg + PW'(pop_n);
         count_next  = count_reg + CW'(push) - pop_n;
      end
   end

   // Queue state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage write; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_op;
      end
   end

   // Head window: peek[k] is the k-th oldest entry, wrapping across the array end.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_peek
      assign peek[gi] = mem[rd_ptr_reg + PW'(gi)];
   end

   assign count = count_reg;

endmodule

// File: rtl/ldst_dispatch.sv
// Load/store dispatch: buffers decoded memory ops and issues up to LANES oldest
// ops per clk, steering each onto either the load or the store lane of its slot.
module ldst_dispatch
   import OpCodes::*;
#(
   parameter  int DEPTH = 8,
   localparam int LANES = REGLD_PER_CLK,
   localparam int W     = NSIG + 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic               op_valid_i,
   output logic               op_ready_o,
   input  logic               op_store_i,
   input  logic [W-1:0]       op_data_i,
   input  logic               stall_i,
   output logic [W-1:0]       Load_o [LANES],
   output logic [LANES-1:0]   load_vld_o,
   output logic [W-1:0]       Store_o [LANES],
   output logic [LANES-1:0]   store_vld_o,
   output logic [CW-1:0]      count_o
);

   logic            push;
   ldst_op_t        push_op;
   ldst_op_t        peek [LANES];
   logic [CW-1:0]   count;
   logic [CW-1:0]   issue_n;
   logic [CW-1:0]   pop_n;

   // Ready looks only at the registered count, so a same-cycle issue never makes room.
   assign op_ready_o = !rst && (count < CW'(DEPTH));
   assign push       = op_valid_i && op_ready_o && !flush_i;
   assign push_op    = '{is_store: op_store_i, data: op_data_i};

   // Group size is bounded by what was queued before this edge (no bypass).
   assign issue_n = (count >= CW'(LANES)) ? CW'(LANES) : count;
   assign pop_n   = (stall_i || flush_i) ? '0 : issue_n;

   ldst_op_fifo #(
      .DEPTH   (DEPTH),
      .LANES   (LANES)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush_i),
      .push    (push),
      .push_op (push_op),
      .pop_n   (pop_n),
      .peek    (peek),
      .count   (count)
   );

   assign count_o = count;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W-1:0] ld_reg, ld_next;
      logic [W-1:0] st_reg, st_next;
      logic         lv_reg, lv_next;
      logic         sv_reg, sv_next;

      // Lane steering: flush clears, stall holds, otherwise slot gi takes the gi-th oldest op.
      always_comb begin
         ld_next = ld_reg;
         st_next = st_reg;
         lv_next = lv_reg;
         sv_next = sv_reg;
         if (flush_i) begin
            ld_next = '0;
            st_next = '0;
            lv_next = 1'b0;
            sv_next = 1'b0;
         end else if (!stall_i) begin
            ld_next = '0;
            st_next = '0;
            lv_next = 1'b0;
            sv_next = 1'b0;
            if (CW'(gi) < issue_n) begin
               if (peek[gi].is_store) begin
                  st_next = peek[gi].data;
                  sv_next = 1'b1;
               end else begin
                  ld_next = peek[gi].data;
                  lv_next = 1'b1;
               end
            end
         end
      end

      // Lane output registers.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ld_reg <= '0;
            st_reg <= '0;
            lv_reg <= 1'b0;
            sv_reg <= 1'b0;
         end else begin
            ld_reg <= ld_next;
            st_reg <= st_next;
            lv_reg <= lv_next;
            sv_reg <= sv_next;
         end
      end

      assign Load_o[gi]      = ld_reg;
      assign Store_o[gi]     = st_reg;
      assign load_vld_o[gi]  = lv_reg;
      assign store_vld_o[gi] = sv_reg;
   end

endmodule

// File: tb/tb_ldst_dispatch.sv
// Bench for ldst_dispatch: directed vector table, hand-written corner sequences
// and random traffic, all checked against a queue-based reference model.
module tb_ldst_dispatch;
   import OpCodes::*;

   localparam int DEPTH = 4;
   localparam int LANES = REGLD_PER_CLK;
   localparam int W     = NSIG + 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             flush_i;
   logic             op_valid_i;
   logic             op_ready_o;
   logic             op_store_i;
   logic [W-1:0]     op_data_i;
   logic             stall_i;
   logic [W-1:0]     load_o  [LANES];
   logic [LANES-1:0] load_vld_o;
   logic [W-1:0]     store_o [LANES];
   logic [LANES-1:0] store_vld_o;
   logic [CW-1:0]    count_o;

   ldst_dispatch #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .op_valid_i  (op_valid_i),
      .op_ready_o  (op_ready_o),
      .op_store_i  (op_store_i),
      .op_data_i   (op_data_i),
      .stall_i     (stall_i),
      .Load_o      (load_o),
      .load_vld_o  (load_vld_o),
      .Store_o     (store_o),
      .store_vld_o (store_vld_o),
      .count_o     (count_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: queue of {is_store, data} in age order plus the lane contents.
   logic [8:0]       q [$];
   logic [7:0]       m_ld [LANES];
   logic [7:0]       m_st [LANES];
   logic [LANES-1:0] m_lv;
   logic [LANES-1:0] m_sv;

   typedef struct {
      logic        v;
      logic        s;
      logic [7:0]  d;
      logic        st;
      logic        fl;
      logic        rdy;
      logic [31:0] cnt;
      logic [1:0]  lv;
      logic [1:0]  sv;
      logic [31:0] lanes;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dut_lanes();
      return {load_o[0], load_o[1], store_o[0], store_o[1]};
   endfunction

   function automatic logic [31:0] model_lanes();
      return {m_ld[0], m_ld[1], m_st[0], m_st[1]};
   endfunction

   task automatic model_clear_lanes();
      for (int k = 0; k < LANES; k++) begin
         m_ld[k] = '0;
         m_st[k] = '0;
      end
      m_lv = '0;
      m_sv = '0;
   endtask

   task automatic model_reset();
      q.delete();
      model_clear_lanes();
   endtask

   // One clock edge of the reference behaviour, evaluated on pre-edge state.
   task automatic model_edge(input logic v, input logic s, input logic [7:0] d,
                             input logic st, input logic fl);
      logic       do_push;
      int         n;
      logic [8:0] e;
      if (fl) begin
         model_reset();
      end else begin
         do_push = v && (q.size() < DEPTH);
         if (!st) begin
            n = (q.size() < LANES) ? q.size() : LANES;
            model_clear_lanes();
            for (int k = 0; k < n; k++) begin
               e = q.pop_front();
               if (e[8]) begin
                  m_st[k] = e[7:0];
                  m_sv[k] = 1'b1;
               end else begin
                  m_ld[k] = e[7:0];
                  m_lv[k] = 1'b1;
               end
            end
         end
         if (do_push) q.push_back({s, d});
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, " count"},     32'(count_o),     32'(q.size()));
      chk({tag, " load_vld"},  32'(load_vld_o),  32'(m_lv));
      chk({tag, " store_vld"}, 32'(store_vld_o), 32'(m_sv));
      chk({tag, " lanes"},     dut_lanes(),      model_lanes());
   endtask

   // Drive one cycle's inputs, check ready before the edge and outputs after it.
   task automatic step(input logic v, input logic s, input logic [7:0] d,
                       input logic st, input logic fl, input string tag,
                       output logic rdy_seen);
      op_valid_i = v;
      op_store_i = s;
      op_data_i  = d;
      stall_i    = st;
      flush_i    = fl;
      #1;
      rdy_seen = op_ready_o;
      chk({tag, " ready"}, 32'(op_ready_o), 32'(q.size() < DEPTH));
      @(posedge clk);
      model_edge(v, s, d, st, fl);
      #1;
      check_model(tag);
   endtask

   function automatic vec_t mk(input logic v, input logic s, input logic [7:0] d,
                               input logic st, input logic rdy, input logic [31:0] cnt,
                               input logic [1:0] lv, input logic [1:0] sv,
                               input logic [31:0] lanes);
      vec_t r;
      r.v = v; r.s = s; r.d = d; r.st = st; r.fl = 1'b0; r.rdy = rdy;
      r.cnt = cnt; r.lv = lv; r.sv = sv; r.lanes = lanes;
      return r;
   endfunction

   initial begin
      logic r;
      logic [31:0] held;
      string tag;

      // Mixed issue split 1+1, then a stalled pair released as one group, then full queue.
      vecs[0]  = mk(1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 32'd1, 2'b00, 2'b00, 32'h0000_0000);
      vecs[1]  = mk(1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 32'd1, 2'b01, 2'b00, 32'h1100_0000);
      vecs[2]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 2'b00, 2'b01, 32'h0000_2200);
      vecs[3]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 2'b00, 2'b00, 32'h0000_0000);
      vecs[4]  = mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 32'd1, 2'b00, 2'b00, 32'h0000_0000);
      vecs[5]  = mk(1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 32'd2, 2'b00, 2'b00, 32'h0000_0000);
      vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 2'b01, 2'b10, 32'h1100_0022);
      vecs[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 2'b00, 2'b00, 32'h0000_0000);
      vecs[8]  = mk(1'b1, 1'b0, 8'h30, 1'b1, 1'b1, 32'd1, 2'b00, 2'b00, 32'h0000_0000);
      vecs[9]  = mk(1'b1, 1'b1, 8'h31, 1'b1, 1'b1, 32'd2, 2'b00, 2'b00, 32'h0000_0000);
      vecs[10] = mk(1'b1, 1'b0, 8'h32, 1'b1, 1'b1, 32'd3, 2'b00, 2'b00, 32'h0000_0000);
      vecs[11] = mk(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 32'd4, 2'b00, 2'b00, 32'h0000_0000);
      vecs[12] = mk(1'b1, 1'b0, 8'h34, 1'b1, 1'b0, 32'd4, 2'b00, 2'b00, 32'h0000_0000);
      vecs[13] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'd2, 2'b01, 2'b10, 32'h3000_0031);
      vecs[14] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 2'b01, 2'b10, 32'h3200_0033);
      vecs[15] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 2'b00, 2'b00, 32'h0000_0000);

      rst = 1'b1; flush_i = 1'b0; op_valid_i = 1'b0; op_store_i = 1'b0;
      op_data_i = '0; stall_i = 1'b0;
      model_reset();
      #1;
      chk("reset ready low", 32'(op_ready_o), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("post-reset ready", 32'(op_ready_o), 32'd1);
      check_model("post-reset");

      for (int i = 0; i < 16; i++) begin
         tag = $sformatf("vec%0d", i);
         step(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].st, vecs[i].fl, tag, r);
         chk({tag, " tbl ready"},     32'(r),           32'(vecs[i].rdy));
         chk({tag, " tbl count"},     32'(count_o),     vecs[i].cnt);
         chk({tag, " tbl load_vld"},  32'(load_vld_o),  32'(vecs[i].lv));
         chk({tag, " tbl store_vld"}, 32'(store_vld_o), 32'(vecs[i].sv));
         chk({tag, " tbl lanes"},     dut_lanes(),      vecs[i].lanes);
      end

      // Async reset with 3 queued ops and live lanes.
      step(1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "rst pre0", r);
      step(1'b1, 1'b1, 8'h02, 1'b1, 1'b0, "rst pre1", r);
      step(1'b1, 1'b0, 8'h03, 1'b0, 1'b0, "rst pre2", r);
      step(1'b1, 1'b1, 8'h04, 1'b1, 1'b0, "rst pre3", r);
      step(1'b1, 1'b0, 8'h05, 1'b1, 1'b0, "rst pre4", r);
      op_valid_i = 1'b0; stall_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("midrst count",     32'(count_o),     32'd0);
      chk("midrst load_vld",  32'(load_vld_o),  32'd0);
      chk("midrst store_vld", 32'(store_vld_o), 32'd0);
      chk("midrst ready",     32'(op_ready_o),  32'd0);
      chk("midrst lanes",     dut_lanes(),      32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst release ready", 32'(op_ready_o), 32'd1);

      // Issue group straddling entries 3 and 0.
      step(1'b1, 1'b0, 8'h40, 1'b1, 1'b0, "wrap0", r);
      step(1'b1, 1'b1, 8'h41, 1'b1, 1'b0, "wrap1", r);
      step(1'b1, 1'b0, 8'h42, 1'b1, 1'b0, "wrap2", r);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "wrap3", r);
      step(1'b1, 1'b1, 8'h43, 1'b0, 1'b0, "wrap4", r);
      step(1'b1, 1'b0, 8'h44, 1'b1, 1'b0, "wrap5", r);
      step(1'b1, 1'b1, 8'h45, 1'b0, 1'b0, "wrap6", r);
      chk("wrap span lanes",     dut_lanes(),      32'h0044_4300);
      chk("wrap span load_vld",  32'(load_vld_o),  32'b10);
      chk("wrap span store_vld", 32'(store_vld_o), 32'b01);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "wrap7", r);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "wrap8", r);

      // Stall hold while pushing.
      step(1'b1, 1'b0, 8'h50, 1'b1, 1'b0, "hold0", r);
      step(1'b1, 1'b1, 8'h51, 1'b1, 1'b0, "hold1", r);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "hold2", r);
      held = 32'h5000_0051;
      for (int i = 0; i < 3; i++) begin
         tag = $sformatf("hold stall%0d", i);
         step(1'b1, 1'(i), 8'(8'h52 + i), 1'b1, 1'b0, tag, r);
         chk({tag, " lanes held"}, dut_lanes(),  held);
         chk({tag, " count rise"}, 32'(count_o), 32'(i + 1));
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "hold release", r);

      // Flush with a push in the same cycle.
      step(1'b1, 1'b0, 8'h60, 1'b1, 1'b0, "flush pre0", r);
      step(1'b1, 1'b1, 8'h61, 1'b1, 1'b0, "flush pre1", r);
      chk("flush pre count", 32'(count_o), 32'd3);
      step(1'b1, 1'b0, 8'h66, 1'b0, 1'b1, "flush", r);
      chk("flush count", 32'(count_o), 32'd0);
      chk("flush vld",   32'({load_vld_o, store_vld_o}), 32'd0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "flush after", r);
      chk("flush dropped push", 32'({load_vld_o, store_vld_o}), 32'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 31) == 0), $sformatf("rand%0d", i), r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
